// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous sprite/text ROM among N_REQ pixel requesters.
//   Round-robin grant (combinational, one-hot). One ROM read can be issued
//   every cycle, and nothing stalls. Each response comes back ROM_LAT+1 clocks
//   after its transfer edge, tagged one-hot with the requester id.
//   Reads at addresses >= ROM_DEPTH still go to the ROM unchanged, but their
//   data is forced to zero, which makes those pixels transparent.
//   Optional build macro: SPRITE_ARB_FIXED_PRIO_EN selects fixed priority
//   (the lowest index always wins, and there is no round-robin pointer).
module sprite_rom_arbiter #(
  parameter int N_REQ     = 4,
  parameter int AW        = 13,
  parameter int DW        = 8,
  parameter int ROM_LAT   = 1,
  parameter int ROM_DEPTH = 4272
) (
  input  logic                  i_clk2,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*AW-1:0]   i_addr,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [AW-1:0]         o_rom_addr,
  input  logic [DW-1:0]         i_rom_data,
  output logic [DW-1:0]         o_rdata,
  output logic [N_REQ-1:0]      o_rvalid,
  output logic                  o_busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // One in-flight read: tag travelling alongside the ROM access
  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           oob;
  } pipe_t;

  pipe_t            pipe_r [0:ROM_LAT];
  pipe_t            stage0_s;
  logic [AW-1:0]    rom_addr_r;
  logic [N_REQ-1:0] rvalid_r;
  logic [DW-1:0]    rdata_r;
  logic             busy_r;

  logic [IDW-1:0]   win_s;
  logic             win_vld_s;
  logic [AW-1:0]    sel_addr_s;
  logic [N_REQ-1:0] rvalid_nxt_s;
  logic [DW-1:0]    rdata_nxt_s;
  logic             busy_nxt_s;

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   ptr_r;
`endif

  // Winner search: first requester at or after the pointer (or from index 0)
  always_comb begin
    int idx_v;
    idx_v     = 0;
    win_s     = '0;
    win_vld_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      idx_v = i;
`else
      idx_v = (int'(ptr_r) + i) % N_REQ;
`endif
      if (!win_vld_s && i_req[idx_v]) begin
        win_vld_s = 1'b1;
        win_s     = IDW'(idx_v);
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // One-hot grant; suppressed while reset is asserted
  always_comb begin
    o_gnt = '0;
    if (i_rst_n && win_vld_s) begin
      o_gnt[win_s] = 1'b1;
    end else begin
      o_gnt = '0;
    end
  end

  // Winner's address and the tag entering the pipeline this cycle
  always_comb begin
    sel_addr_s = i_addr[int'(win_s)*AW +: AW];
    stage0_s   = '0;
    if (win_vld_s) begin
      stage0_s.valid = 1'b1;
      stage0_s.id    = win_s;
      stage0_s.oob   = (32'(sel_addr_s) >= 32'(ROM_DEPTH));
    end else begin
      stage0_s = '0;
    end
  end

  // Next-state values for the registered response and busy outputs
  always_comb begin
    rvalid_nxt_s = '0;
    rdata_nxt_s  = '0;
    busy_nxt_s   = stage0_s.valid;
    for (int i = 0; i < ROM_LAT; i++) begin
      busy_nxt_s = busy_nxt_s | pipe_r[i].valid;
    end
    if (pipe_r[ROM_LAT].valid) begin
      rvalid_nxt_s[pipe_r[ROM_LAT].id] = 1'b1;
      if (!pipe_r[ROM_LAT].oob) begin
        rdata_nxt_s = i_rom_data;
      end else begin
        rdata_nxt_s = '0;
      end
    end else begin
      rvalid_nxt_s = '0;
    end
  end

  // ROM address register, tag pipeline and response registers
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_addr_r <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        pipe_r[i] <= '0;
      end
      rvalid_r   <= '0;
      rdata_r    <= '0;
      busy_r     <= 1'b0;
    end else begin
      if (win_vld_s) begin
        rom_addr_r <= sel_addr_s;
      end else begin
        rom_addr_r <= rom_addr_r;
      end
      pipe_r[0] <= stage0_s;
      for (int i = 1; i <= ROM_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      rvalid_r   <= rvalid_nxt_s;
      rdata_r    <= rdata_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

`ifndef SPRITE_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the requester that was served
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_r <= '0;
    end else if (win_vld_s) begin
      ptr_r <= IDW'((int'(win_s) + 1) % N_REQ);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  assign o_rom_addr = rom_addr_r;
  assign o_rvalid   = rvalid_r;
  assign o_rdata    = rdata_r;
  assign o_busy     = busy_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//   Randomized and directed stimulus, checked against a transaction-level
//   reference model. The model keeps a queue of expected responses, each with
//   its due edge count. The ROM is modelled with a ROM_LAT-deep address delay.
module tb_sprite_rom_arbiter;

  localparam int N_REQ     = 4;
  localparam int AW        = 13;
  localparam int DW        = 8;
  localparam int ROM_LAT   = 1;
  localparam int ROM_DEPTH = 4272;

  logic                i_clk2 = 1'b0;
  logic                i_rst_n;
  logic [N_REQ-1:0]    i_req;
  logic [N_REQ*AW-1:0] i_addr;
  logic [N_REQ-1:0]    o_gnt;
  logic [AW-1:0]       o_rom_addr;
  logic [DW-1:0]       i_rom_data;
  logic [DW-1:0]       o_rdata;
  logic [N_REQ-1:0]    o_rvalid;
  logic                o_busy;

  always #5 i_clk2 = ~i_clk2;

  sprite_rom_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT), .ROM_DEPTH(ROM_DEPTH)
  ) dut (
    .i_clk2(i_clk2), .i_rst_n(i_rst_n), .i_req(i_req), .i_addr(i_addr),
    .o_gnt(o_gnt), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_busy(o_busy)
  );

  // ROM image covers the whole address space, so out-of-range reads return nonzero data
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] rom_dly [0:ROM_LAT-1];

  // Synchronous ROM: data follows the address ROM_LAT clocks later
  always @(posedge i_clk2) begin
    rom_dly[0] <= o_rom_addr;
    for (int i = 1; i < ROM_LAT; i++) rom_dly[i] <= rom_dly[i-1];
  end
  assign i_rom_data = mem[rom_dly[ROM_LAT-1]];

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  int            m_ptr;
  int            n_edges;
  logic [AW-1:0] m_rom_addr;
  int            rv_count;
  int            n_checks;
  int            n_errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N_REQ*AW-1:0] slot(input int k, input logic [AW-1:0] a);
    logic [N_REQ*AW-1:0] v;
    v = '0;
    v[k*AW +: AW] = a;
    return v;
  endfunction

  // One clock of stimulus: drive, check the current outputs, then advance the model
  task automatic do_cycle(input logic [N_REQ-1:0] req, input logic [N_REQ*AW-1:0] addr);
    int               g;
    int               k;
    resp_t            r;
    logic [N_REQ-1:0] exp_gnt;
    logic [N_REQ-1:0] exp_rv;
    logic [DW-1:0]    exp_rd;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    i_req  = req;
    i_addr = addr;
    #1;
    g = -1;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef SPRITE_ARB_FIXED_PRIO_EN
      k = i;
`else
      k = (m_ptr + i) % N_REQ;
`endif
      if (g < 0 && req[k]) g = k;
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check_eq("gnt", 32'(o_gnt), 32'(exp_gnt));
    exp_rv = '0;
    exp_rd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == n_edges) begin
      r = exp_q.pop_front();
      exp_rv[r.id] = 1'b1;
      exp_rd = r.data;
      rv_count++;
    end
    check_eq("rvalid", 32'(o_rvalid), 32'(exp_rv));
    check_eq("rdata", 32'(o_rdata), 32'(exp_rd));
    check_eq("busy", 32'(o_busy), 32'(exp_q.size() > 0));
    check_eq("rom_addr", 32'(o_rom_addr), 32'(m_rom_addr));
    @(posedge i_clk2);
    n_edges++;
    if (g >= 0) begin
      a = addr[g*AW +: AW];
      d = (32'(a) < ROM_DEPTH) ? mem[a] : {DW{1'b0}};
      m_rom_addr = a;
      exp_q.push_back('{due: n_edges + ROM_LAT + 1, id: g, data: d});
      m_ptr = (g + 1) % N_REQ;
    end
    @(negedge i_clk2);
  endtask

  task automatic drain();
    repeat (ROM_LAT + 3) do_cycle('0, '0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_rom_addr = '0;
  endtask

  initial begin
    int                  start_cnt;
    logic [N_REQ-1:0]    rq;
    logic [N_REQ*AW-1:0] ad;
    logic [AW-1:0]       a;
    n_checks = 0;
    n_errors = 0;
    n_edges  = 0;
    rv_count = 0;
    model_reset();
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom_range(1, (1 << DW) - 1));
    mem[100] = 8'h5A;
    for (int i = 0; i < ROM_LAT; i++) rom_dly[i] = '0;

    // Reset state, with requests present
    i_rst_n = 1'b0;
    i_req   = 4'b1111;
    i_addr  = '1;
    repeat (2) @(negedge i_clk2);
    check_eq("rst_gnt", 32'(o_gnt), 32'd0);
    check_eq("rst_rvalid", 32'(o_rvalid), 32'd0);
    check_eq("rst_rdata", 32'(o_rdata), 32'd0);
    check_eq("rst_rom_addr", 32'(o_rom_addr), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    i_req   = '0;
    i_rst_n = 1'b1;

    // Reset in the middle of a stream, with two reads in flight
    do_cycle(4'b0001, slot(0, 13'd10));
    do_cycle(4'b0010, slot(1, 13'd20));
    i_req   = 4'b1111;
    i_rst_n = 1'b0;
    #1;
    check_eq("midrst_rvalid", 32'(o_rvalid), 32'd0);
    check_eq("midrst_rom_addr", 32'(o_rom_addr), 32'd0);
    check_eq("midrst_busy", 32'(o_busy), 32'd0);
    check_eq("midrst_gnt", 32'(o_gnt), 32'd0);
    @(posedge i_clk2);
    @(negedge i_clk2);
    check_eq("midrst_rvalid2", 32'(o_rvalid), 32'd0);
    i_rst_n = 1'b1;
    model_reset();
    drain();

    // Round-robin with every requester active
    ad = '0;
    for (int k = 0; k < N_REQ; k++) ad[k*AW +: AW] = AW'(200 + k);
    repeat (8) do_cycle(4'b1111, ad);
    drain();

    // Single read from requester 2
    do_cycle(4'b0100, slot(2, 13'd100));
    drain();

    // Streaming sweep from requester 1
    start_cnt = rv_count;
    for (int a2 = 0; a2 < 356; a2++) do_cycle(4'b0010, slot(1, AW'(a2)));
    drain();
    check_eq("stream_pulses", 32'(rv_count - start_cnt), 32'd356);

    // Out-of-range and boundary addresses
    do_cycle(4'b0001, slot(0, 13'd4272));
    do_cycle(4'b0001, slot(0, 13'd8191));
    do_cycle(4'b0001, slot(0, 13'd4271));
    drain();

    // Two requesters held (fixed priority lets requester 1 win every time)
    do_cycle(4'b1010, slot(1, 13'd300) | slot(3, 13'd301));
    do_cycle(4'b1010, slot(1, 13'd302) | slot(3, 13'd303));
    do_cycle(4'b1010, slot(1, 13'd304) | slot(3, 13'd305));
    do_cycle(4'b1010, slot(1, 13'd306) | slot(3, 13'd307));
    drain();

    // Random traffic: withdrawals, address changes while waiting, out-of-range reads
    for (int n = 0; n < 3000; n++) begin
      rq = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      ad = '0;
      for (int k = 0; k < N_REQ; k++) begin
        if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(ROM_DEPTH, (1 << AW) - 1));
        else                           a = AW'($urandom_range(0, ROM_DEPTH - 1));
        ad[k*AW +: AW] = a;
      end
      do_cycle(rq, ad);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
